lfsr_bank: RTL and testbench

- Bank of CHANNELS independent Fibonacci LFSRs, each LFSR_W bits, giving one pseudo-random bit per channel per advance.
- Feeds the visualiser's sparkle/noise layers.
- Adds over the earlier fixed 48x16 generator: runtime reseed handshake, warm-up phase, advance enable with output valid, and a sticky zero-lock fault flag.

---
 rtl/lfsr_pkg.sv | 36 +++
 rtl/lfsr_bank_cell.sv | 36 +++
 rtl/lfsr_bank.sv | 164 ++++++++++++++++
 tb/tb_lfsr_bank.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR bank: FSM state type, tap masks and seed spreading.
package lfsr_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StWarmup,
    StRun
  } lfsr_state_e;

  // Fibonacci tap mask for a legal register width; 0 for unsupported widths.
  function automatic logic [31:0] taps(input int unsigned width);
    logic [31:0] mask;
    case (width)
      8:       mask = 32'h0000_00B8;  // bits 7,5,4,3
      16:      mask = 32'h0000_B400;  // bits 15,13,12,10
      24:      mask = 32'h00E1_0000;  // bits 23,22,21,16
      32:      mask = 32'h8020_0003;  // bits 31,21,1,0
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

  // Per-channel seed: base XOR stride*(idx+1), truncated to width; an all-zero
  // result would lock the LFSR, so it becomes 1.
  function automatic logic [31:0] derive_seed(input logic [31:0] base, input int unsigned idx,
                                              input int unsigned stride,
                                              input int unsigned width);
    logic [31:0] mask;
    logic [31:0] s;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    s    = (base ^ (stride * (idx + 1))) & mask;
    if (s == 32'd0) s = 32'd1;
    return s;
  endfunction

endpackage

// File: rtl/lfsr_bank_cell.sv
// Single Fibonacci LFSR channel with zero-state guard.
module lfsr_cell
  import lfsr_pkg::*;
#(
  parameter int unsigned       LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(taps(LFSR_W)),
  parameter logic [LFSR_W-1:0] RST_SEED = {{(LFSR_W-1){1'b0}}, 1'b1}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_state,
  output logic              o_fb,
  output logic              o_zero
);

  logic [LFSR_W-1:0] state_q;

  assign o_state = state_q;
  assign o_fb    = ^(state_q & TAPS);
  assign o_zero  = (state_q == '0);

  // Seed load wins over step; a zero state is repaired to 1 instead of shifting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RST_SEED;
    end else if (i_load) begin
      state_q <= i_seed;
    end else if (i_step) begin
      state_q <= o_zero ? {{(LFSR_W-1){1'b0}}, 1'b1} : {state_q[LFSR_W-2:0], o_fb};
    end
  end

endmodule

// File: rtl/lfsr_bank.sv
// Bank of CHANNELS Fibonacci LFSRs with reseed handshake, warm-up phase, advance enable
// and sticky zero-lock fault flag.
// Optional macro LFSR_BANK_READBACK_EN adds i_sel/o_state registered state readback.
module lfsr_bank
  import lfsr_pkg::*;
#(
  parameter int unsigned       CHANNELS     = 48,
  parameter int unsigned       LFSR_W       = 16,
  parameter int unsigned       WARMUP       = 16,
  parameter int unsigned       SEED_STRIDE  = 177,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_seed_valid,
  input  logic [LFSR_W-1:0]   i_seed,
  output logic                o_seed_ready,
  output logic [CHANNELS-1:0] o_random,
  output logic                o_valid,
  output logic                o_busy,
  output logic                o_fault
`ifdef LFSR_BANK_READBACK_EN
  ,
  input  logic [$clog2(CHANNELS)-1:0] i_sel,
  output logic [LFSR_W-1:0]           o_state
`endif
);

  localparam int unsigned       CntW     = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CntW-1:0]   WarmCnt  = CntW'(WARMUP);
  localparam logic [LFSR_W-1:0] Taps     = LFSR_W'(taps(LFSR_W));
  // With no warm-up the bank is usable straight out of reset and after every load.
  localparam lfsr_state_e       RstState = (WARMUP == 0) ? StRun : StWarmup;

  lfsr_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [LFSR_W-1:0] seed_q;

  logic accept;
  logic load;
  logic step;
  logic run_adv;

  logic [CHANNELS-1:0] fb;
  logic [CHANNELS-1:0] zero;
`ifdef LFSR_BANK_READBACK_EN
  logic [LFSR_W-1:0] cell_state [CHANNELS];
`endif

  // FSM state and warm-up counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RstState;
      cnt_q   <= WarmCnt;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; an accepted seed overrides everything and restarts via LOAD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLoad: begin
        cnt_d   = WarmCnt;
        state_d = RstState;
      end
      StWarmup: begin
        if (step) begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = RstState;
    endcase
    if (accept) state_d = StLoad;
  end

  // FSM-decoded controls and handshake outputs.
  always_comb begin
    o_seed_ready = (state_q != StLoad);
    o_busy       = (state_q != StRun);
    accept       = i_seed_valid & o_seed_ready;
    load         = (state_q == StLoad);
    run_adv      = (state_q == StRun) & i_en & ~accept;
    step         = ((state_q == StWarmup) & ~accept) | run_adv;
  end

  // Base seed capture on accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seed_q <= DEFAULT_SEED;
    end else if (accept) begin
      seed_q <= i_seed;
    end
  end

  // Output bits update only on RUN advances; fault is sticky until the next load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_random <= '0;
      o_valid  <= 1'b0;
      o_fault  <= 1'b0;
    end else begin
      o_valid <= run_adv;
      if (run_adv) o_random <= fb;
      if (load) begin
        o_fault <= 1'b0;
      end else if (step && (zero != '0)) begin
        o_fault <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
    localparam logic [LFSR_W-1:0] RstSeed =
        LFSR_W'(derive_seed(32'(DEFAULT_SEED), i, SEED_STRIDE, LFSR_W));

    logic [LFSR_W-1:0] load_seed;
    logic [LFSR_W-1:0] state;

    assign load_seed = LFSR_W'(derive_seed(32'(seed_q), i, SEED_STRIDE, LFSR_W));

    lfsr_cell #(
      .LFSR_W  (LFSR_W),
      .TAPS    (Taps),
      .RST_SEED(RstSeed)
    ) u_cell (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (load),
      .i_seed (load_seed),
      .i_step (step),
      .o_state(state),
      .o_fb   (fb[i]),
      .o_zero (zero[i])
    );

`ifdef LFSR_BANK_READBACK_EN
    assign cell_state[i] = state;
`else
    logic unused_state;
    assign unused_state = ^state;
`endif
  end

`ifdef LFSR_BANK_READBACK_EN
  // Registered readback of the selected channel; out-of-range selects read 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_state <= '0;
    end else if (32'(i_sel) < CHANNELS) begin
      o_state <= cell_state[i_sel];
    end else begin
      o_state <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_bank.sv
// Self-checking bench for lfsr_bank: behavioural model compared every cycle plus literal pins.
module tb_lfsr_bank;

  localparam int unsigned CH = 48;
  localparam int unsigned W  = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_en;
  logic          i_seed_valid;
  logic [W-1:0]  i_seed;
  logic          o_seed_ready;
  logic [CH-1:0] o_random;
  logic          o_valid;
  logic          o_busy;
  logic          o_fault;

  lfsr_bank #(
    .CHANNELS    (CH),
    .LFSR_W      (W),
    .WARMUP      (16),
    .SEED_STRIDE (177),
    .DEFAULT_SEED(16'h0000)
  ) u_dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_seed_valid(i_seed_valid),
    .i_seed      (i_seed),
    .o_seed_ready(o_seed_ready),
    .o_random    (o_random),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_fault     (o_fault)
  );

  always #5 i_clk = ~i_clk;

  logic [W-1:0] ch0, ch3, ch5;
  assign ch0 = u_dut.gen_ch[0].u_cell.state_q;
  assign ch3 = u_dut.gen_ch[3].u_cell.state_q;
  assign ch5 = u_dut.gen_ch[5].u_cell.state_q;

  // ---------------- behavioural model ----------------
  logic [W-1:0]  m_st [CH];
  logic [W-1:0]  m_seed;
  bit            m_load;
  int            m_warm;
  logic [CH-1:0] m_rand;
  bit            m_valid;
  bit            m_fault;
  bit            zap;  // bench forced channel 5 to zero before this edge

  function automatic logic [W-1:0] mseed(input logic [W-1:0] base, input int i);
    int unsigned v;
    v = (32'(base) ^ (177 * (i + 1))) & 32'hFFFF;
    if (v == 0) v = 1;
    return W'(v);
  endfunction

  function automatic logic mfb(input logic [W-1:0] s);
    return s[15] ^ s[13] ^ s[12] ^ s[10];
  endfunction

  always @(posedge i_clk or posedge i_rst) begin : model
    if (i_rst) begin
      for (int i = 0; i < CH; i++) m_st[i] <= mseed(16'h0000, i);
      m_seed  <= '0;
      m_load  <= 1'b0;
      m_warm  <= 16;
      m_rand  <= '0;
      m_valid <= 1'b0;
      m_fault <= 1'b0;
    end else if (m_load) begin
      for (int i = 0; i < CH; i++) m_st[i] <= mseed(m_seed, i);
      m_fault <= 1'b0;
      m_valid <= 1'b0;
      m_load  <= 1'b0;
      m_warm  <= 16;
    end else begin : adv_blk
      logic          acc;
      logic          adv;
      logic          hit;
      logic [CH-1:0] bits;
      logic [W-1:0]  cur;
      acc = i_seed_valid;
      adv = !acc && (m_warm > 0 || i_en);
      m_valid <= 1'b0;
      if (adv) begin
        hit  = 1'b0;
        bits = '0;
        for (int i = 0; i < CH; i++) begin
          cur = m_st[i];
          if (zap && i == 5) cur = '0;
          if (cur == '0) begin
            m_st[i] <= 16'h0001;
            bits[i] = 1'b0;
            hit     = 1'b1;
          end else begin
            m_st[i] <= {cur[W-2:0], mfb(cur)};
            bits[i] = mfb(cur);
          end
        end
        if (hit) m_fault <= 1'b1;
        if (m_warm > 0) begin
          m_warm <= m_warm - 1;
        end else begin
          m_rand  <= bits;
          m_valid <= 1'b1;
        end
      end
      if (acc) begin
        m_seed <= i_seed;
        m_load <= 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Advance to the next falling edge and compare every output against the model.
  task automatic tick();
    logic exp_busy;
    @(negedge i_clk);
    if (!i_rst) begin
      exp_busy = m_load || (m_warm != 0);
      n_total++;
      if (o_valid === m_valid && o_busy === exp_busy && o_seed_ready === !m_load &&
          o_fault === m_fault && o_random === m_rand && ch0 === m_st[0] && ch3 === m_st[3]) begin
        n_pass++;
      end else begin
        $display("FAIL cycle t=%0t valid %b/%b busy %b/%b ready %b/%b fault %b/%b random %h/%h ch0 %h/%h ch3 %h/%h",
                 $time, o_valid, m_valid, o_busy, exp_busy, o_seed_ready, !m_load, o_fault,
                 m_fault, o_random, m_rand, ch0, m_st[0], ch3, m_st[3]);
      end
    end
  endtask

  // After reset release: 16 warm-up advances, then RUN with channel 0 at 0x00B1 stepped 16x.
  task automatic post_reset(input string tag);
    repeat (15) tick();
    check({tag, " busy before last warmup"}, 64'(o_busy), 64'd1);
    tick();
    check({tag, " busy falls"}, 64'(o_busy), 64'd0);
    check({tag, " seed_ready"}, 64'(o_seed_ready), 64'd1);
    check({tag, " ch0 post-warmup"}, 64'(ch0), 64'h11DF);
    check({tag, " model ch0 post-warmup"}, 64'(m_st[0]), 64'h11DF);
  endtask

  task automatic mid_reset(input string tag);
    #2 i_rst = 1'b1;
    #1;
    check({tag, " rst o_random"}, 64'(o_random), 64'd0);
    check({tag, " rst o_valid"}, 64'(o_valid), 64'd0);
    check({tag, " rst o_fault"}, 64'(o_fault), 64'd0);
    check({tag, " rst o_busy"}, 64'(o_busy), 64'd1);
    i_en = 1'b0;
    i_seed_valid = 1'b0;
    @(negedge i_clk);
    #2 i_rst = 1'b0;
    post_reset({tag, " restart"});
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40 && o_busy; k++) tick();
    check({tag, " idle"}, 64'(o_busy), 64'd0);
  endtask

  bit seen [65536];
  int reps;
  int vlow;
  int nb;

  initial begin
    i_rst = 1'b1;
    i_en = 1'b0;
    i_seed_valid = 1'b0;
    i_seed = '0;
    zap = 1'b0;
    #11;
    check("reset o_random", 64'(o_random), 64'd0);
    check("reset o_valid", 64'(o_valid), 64'd0);
    check("reset o_fault", 64'(o_fault), 64'd0);
    check("reset ch0", 64'(ch0), 64'h00B1);
    #1 i_rst = 1'b0;
    post_reset("first");

    // Full period on channel 0.
    i_en = 1'b1;
    reps = 0;
    vlow = 0;
    for (int k = 1; k <= 65535; k++) begin
      tick();
      if (!o_valid) vlow++;
      if (k < 65535) begin
        if (ch0 == 16'h11DF || seen[ch0]) reps++;
        seen[ch0] = 1'b1;
      end
    end
    check("period return", 64'(ch0), 64'h11DF);
    check("no early repeat", 64'(reps), 64'd0);
    check("valid every advance", 64'(vlow), 64'd0);

    // Enable toggling 1,0,1.
    i_en = 1'b1; tick(); check("toggle valid 1", 64'(o_valid), 64'd1);
    i_en = 1'b0; tick(); check("toggle valid 0", 64'(o_valid), 64'd0);
    i_en = 1'b1; tick(); check("toggle valid 1 again", 64'(o_valid), 64'd1);

    // Seed offered together with an advance request.
    i_seed_valid = 1'b1;
    i_seed = 16'h1234;
    tick();
    i_seed_valid = 1'b0;
    i_en = 1'b0;
    check("no valid on accept", 64'(o_valid), 64'd0);
    check("ready low in load", 64'(o_seed_ready), 64'd0);
    nb = o_busy ? 1 : 0;
    tick();
    check("ch3 seed", 64'(ch3), 64'h10F0);
    check("model ch3 seed", 64'(m_st[3]), 64'h10F0);
    check("ready after load", 64'(o_seed_ready), 64'd1);
    for (int k = 0; k < 40 && o_busy; k++) begin
      nb++;
      tick();
    end
    check("busy length", 64'(nb), 64'd17);

    // Randomized traffic with occasional reseeds.
    for (int k = 0; k < 400; k++) begin
      i_en = 1'($urandom % 2);
      i_seed_valid = (($urandom % 20) == 0);
      i_seed = 16'($urandom);
      tick();
    end
    i_en = 1'b0;
    i_seed_valid = 1'b0;
    wait_idle("random");

    // Seed that derives zero for channel 0.
    i_seed_valid = 1'b1;
    i_seed = 16'h00B1;
    tick();
    i_seed_valid = 1'b0;
    tick();
    check("ch0 zero seed forced to 1", 64'(ch0), 64'd1);
    check("fault clear after load", 64'(o_fault), 64'd0);
    wait_idle("zero seed");

    // Zero-lock injection on channel 5.
    force u_dut.gen_ch[5].u_cell.state_q = 16'h0000;
    #1 release u_dut.gen_ch[5].u_cell.state_q;
    zap = 1'b1;
    i_en = 1'b1;
    tick();
    zap = 1'b0;
    i_en = 1'b0;
    check("fault set", 64'(o_fault), 64'd1);
    check("zero-guard random bit", 64'(o_random[5]), 64'd0);
    check("ch5 reloads 1", 64'(ch5), 64'd1);
    i_en = 1'b1;
    repeat (5) tick();
    i_en = 1'b0;
    check("fault sticky", 64'(o_fault), 64'd1);
    i_seed_valid = 1'b1;
    i_seed = 16'hBEEF;
    tick();
    i_seed_valid = 1'b0;
    check("fault held in load", 64'(o_fault), 64'd1);
    tick();
    check("fault cleared by reseed", 64'(o_fault), 64'd0);

    // Reset during warm-up, then during RUN.
    repeat (4) tick();
    mid_reset("mid-warmup");
    i_en = 1'b1;
    repeat (20) tick();
    mid_reset("mid-run");

    for (int k = 0; k < 100; k++) begin
      i_en = 1'($urandom % 2);
      tick();
    end
    i_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
